// File: rtl/chk_even_pkg.sv
// Shared types and defaults for the even-parity serial receiver.
package chk_even_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } rx_state_t;

endpackage

// File: rtl/even_par_calc.sv
// Combinational parity reduction: odd is high when the vector holds an odd number of ones.
module even_par_calc #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] in,
  output logic         odd
);

  assign odd = ^in;

endmodule

// File: rtl/chk_even_rx.sv
// Even-parity serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Define CHK_EVEN_RX_ERRCNT_EN to build the saturating rejected-frame counter.
module chk_even_rx
  import chk_even_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sh;
  logic              par_bit;
  logic              odd;
  logic              stop_eval, bad_frame, bad_par, good_frame;

  even_par_calc #(.W(DATA_W + 1)) u_par (
    .in  ({par_bit, sh}),
    .odd (odd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      unique case (state)
        IDLE: if (!rx_in) state_nxt = DATA;
        DATA: if (idx == IDX_LAST) state_nxt = PAR;
        PAR:  state_nxt = STOP;
        STOP: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stop sample decides the frame; a low stop bit masks any parity verdict.
  always_comb begin
    busy       = (state != IDLE);
    stop_eval  = bit_en && (state == STOP);
    bad_frame  = stop_eval && !rx_in;
    bad_par    = stop_eval && rx_in && odd;
    good_frame = stop_eval && rx_in && !odd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= good_frame;
      parity_err <= bad_par;
      frame_err  <= bad_frame;
      if (good_frame) data_out <= sh;
      if (bit_en) begin
        unique case (state)
          IDLE: if (!rx_in) idx <= '0;
          DATA: begin
            sh[idx] <= rx_in;
            idx     <= idx + IDX_W'(1);
          end
          PAR:  par_bit <= rx_in;
          default: ;
        endcase
      end
    end
  end

`ifdef CHK_EVEN_RX_ERRCNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((bad_frame || bad_par) && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_chk_even_rx.sv
// Self-checking bench for chk_even_rx: table-driven frames plus reset, back-to-back and saturation sequences.
module tb_chk_even_rx;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_en;
  logic          rx_in;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_err, frame_err, busy;
  logic [CW-1:0] err_cnt;

  chk_even_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_VALID, K_PERR, K_FERR} kind_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          stop;
    kind_t         kind;
  } vec_t;

  typedef struct {
    logic          dv, pe, fe;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m_data   = '0;
  logic [CW-1:0] m_cnt    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [DW-1:0] d, input logic p, input logic s);
    if (!s)         return K_FERR;
    if ((^d) ^ p)   return K_PERR;
    return K_VALID;
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input kind_t k);
    exp_t e;
    if (k == K_VALID) m_data = d;
`ifdef CHK_EVEN_RX_ERRCNT_EN
    if (k != K_VALID && m_cnt != '1) m_cnt = m_cnt + CW'(1);
`endif
    e.dv   = (k == K_VALID);
    e.pe   = (k == K_PERR);
    e.fe   = (k == K_FERR);
    e.data = m_data;
    e.cnt  = m_cnt;
    sb.push_back(e);
  endtask

  task automatic tick(input logic b);
    @(negedge clk);
    rx_in  = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    rx_in  = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input kind_t k);
    tick(1'b0);
    for (int unsigned i = 0; i < DW; i++) tick(d[i]);
    tick(p);
    push_exp(d, k);
    tick(s);
  endtask

  always @(negedge clk) begin
    if (!rst && (data_valid || parity_err || frame_err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: dv=%0b pe=%0b fe=%0b with empty scoreboard at %0t",
                 data_valid, parity_err, frame_err, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_valid", 32'(data_valid), 32'(e.dv));
        chk("parity_err", 32'(parity_err), 32'(e.pe));
        chk("frame_err",  32'(frame_err),  32'(e.fe));
        chk("data_out",   32'(data_out),   32'(e.data));
        chk("err_cnt",    32'(err_cnt),    32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{data: 4'b1011, par: 1'b1, stop: 1'b1, kind: K_VALID};
    vecs[1] = '{data: 4'b1011, par: 1'b0, stop: 1'b1, kind: K_PERR};
    vecs[2] = '{data: 4'h5,    par: 1'b0, stop: 1'b0, kind: K_FERR};
    vecs[3] = '{data: 4'h0,    par: 1'b0, stop: 1'b1, kind: K_VALID};
    vecs[4] = '{data: 4'hF,    par: 1'b1, stop: 1'b1, kind: K_PERR};
    vecs[5] = '{data: 4'h7,    par: 1'b1, stop: 1'b1, kind: K_VALID};
    vecs[6] = '{data: 4'h8,    par: 1'b0, stop: 1'b0, kind: K_FERR};
    vecs[7] = '{data: 4'hC,    par: 1'b0, stop: 1'b1, kind: K_VALID};

    rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",       32'(busy),       32'(0));
    chk("rst_data_out",   32'(data_out),   32'(0));
    chk("rst_data_valid", 32'(data_valid), 32'(0));
    chk("rst_parity_err", 32'(parity_err), 32'(0));
    chk("rst_frame_err",  32'(frame_err),  32'(0));
    chk("rst_err_cnt",    32'(err_cnt),    32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].kind);
      repeat (2) @(negedge clk);
    end

    // Abandon a frame after two data bits; rst and a start-bit strobe coincide.
    tick(1'b0); tick(1'b1); tick(1'b1);
    chk("busy_mid_frame", 32'(busy), 32'(1));
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; rx_in = 1'b0;
    @(negedge clk);
    rst = 1'b0; bit_en = 1'b0; rx_in = 1'b1;
    m_data = '0; m_cnt = '0;
    chk("busy_after_rst",     32'(busy),     32'(0));
    chk("data_out_after_rst", 32'(data_out), 32'(0));
    chk("err_cnt_after_rst",  32'(err_cnt),  32'(0));
    repeat (3) @(negedge clk);
    chk("busy_idle_after_rst", 32'(busy), 32'(0));
    send_frame(4'h3, 1'b0, 1'b1, K_VALID);
    repeat (2) @(negedge clk);

    send_frame(4'h1, 1'b1, 1'b1, classify(4'h1, 1'b1, 1'b1));
    send_frame(4'h2, 1'b1, 1'b1, classify(4'h2, 1'b1, 1'b1));
    send_frame(4'hF, 1'b0, 1'b1, classify(4'hF, 1'b0, 1'b1));
    repeat (2) @(negedge clk);

    for (int i = 0; i < 260; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom_range(0, 15));
      send_frame(d, ~(^d), 1'b1, K_PERR);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
`ifdef CHK_EVEN_RX_ERRCNT_EN
    chk("err_cnt_saturated", 32'(err_cnt), 32'(8'hFF));
`else
    chk("err_cnt_tied_zero", 32'(err_cnt), 32'(0));
`endif
    chk("busy_final", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
